adder_share_arb: RTL and testbench
==================================

Name: adder_share_arb

Overview:
Round-robin arbiter and sequencer that shares one W-bit unsigned adder among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester, latches its operands and computes the registered W+1-bit sum. It then returns the sum with the requester ID on a single valid/ready response channel. It sits between the requesting datapaths and the shared adder resource.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, operand width in bits; the sum is W+1 bits
IDW, 2, requester ID width; must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  bit i: requester i has operands pending
req_a  input  NREQ*W  operand a; requester i occupies bits [i*W +: W]
req_b  input  NREQ*W  operand b; same packing as req_a
req_ready  output  NREQ  one-hot grant/accept; bit i high means operands of requester i are taken this cycle
rsp_valid  output  1  response holds a valid sum
rsp_id  output  IDW  ID of the requester that owns rsp_sum
rsp_sum  output  W+1  a+b, zero-extended and carry-preserving
rsp_ready  input  1  consumer accepts the response
busy  output  1  high in CALC or RESP
txn_cnt  output  8  completed-transaction counter, saturates at 255

Behaviour:
- Reset (async assert, sync-to-clk deassert by the system): state=IDLE, rr_ptr=0, rsp_valid=0, rsp_id=0, rsp_sum=0, req_ready=0, busy=0, txn_cnt=0. Any in-flight transaction is discarded with no response.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant = the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[grant]=1 combinationally in the same cycle; all other bits are 0.
  - On that edge, latch a_q, b_q and id_q=grant; go to CALC.
  - If no req_valid bit is set, req_ready=0 and the FSM stays in IDLE.
- CALC (1 cycle): rsp_sum <= a_q + b_q (W+1 bits, no truncation); rsp_id <= id_q; go to RESP. req_ready=0.
- RESP: rsp_valid=1. rsp_sum and rsp_id are held stable until the handshake.
  - On rsp_valid && rsp_ready: rr_ptr <= (id_q+1) mod NREQ; txn_cnt <= txn_cnt+1 unless it is already 255; go to IDLE.
  - rsp_valid drops on the cycle after the handshake.
- req_ready is 0 in CALC and RESP. Requesters must hold req_valid and operands stable until they see req_ready=1. Deasserting req_valid before the grant is legal; the request simply withdraws.
- Latency: grant edge at T, rsp_valid=1 from T+2. Minimum period is 3 cycles per transaction when rsp_ready is held at 1.
- Fairness: a continuously requesting requester waits at most NREQ-1 transactions.
- rr_ptr updates only on response completion; it does not move on a grant.
- Max sum is 2^(W+1)-2, e.g. 15+15=30 for W=4; the carry lands in rsp_sum[W].

Test Plan:
- Single request: reset, then req_valid=0001, a0=3, b0=4 -> req_ready=0001 for 1 cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_sum=7; txn_cnt=1 after handshake.
- Carry: requester 2, a=15, b=15, rsp_ready=1 -> rsp_sum=30 (5'b11110), rsp_id=2.
- Round robin: req_valid=1111 held, all operands distinct, rsp_ready=1 -> grant order 0,1,2,3,0; one response every 3 cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with req_valid=0010 pending -> rsp_valid, rsp_sum and rsp_id stable; req_ready stays 0; the grant goes to requester 1 only after the handshake.
- Reset mid-operation: drop rst_n while in CALC -> outputs are zero immediately; after release rr_ptr=0, no stale response appears, and the next request completes normally.
- Saturation: run 260 transactions -> txn_cnt reaches 255 and stays there.

Source files
------------

// File: rtl/adder_share_arb.sv
// Round-robin arbiter that time-shares one W-bit adder among NREQ requesters.
// A request is granted in IDLE, summed in CALC, and returned on a single response channel in RESP.
module adder_share_arb #(
   parameter int NREQ = 4,
   parameter int W    = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   output logic [IDW-1:0]    rsp_id,
   output logic [W:0]        rsp_sum,
   input  logic              rsp_ready,
   output logic              busy,
   output logic [7:0]        txn_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_RESP} state_t;

   state_t         r_state, w_state_next;
   logic [IDW-1:0] r_rr_ptr, r_id, r_rsp_id;
   logic [W-1:0]   r_a, r_b;
   logic [W:0]     r_sum;
   logic [7:0]     r_txn_cnt;

   logic [IDW-1:0] w_grant_id, w_ptr_next;
   logic           w_grant_found, w_take, w_done;
   logic [W-1:0]   w_grant_a, w_grant_b;
   int             w_idx;

   // Scan from the farthest candidate back to rr_ptr so the nearest valid one wins.
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_id    = '0;
      w_idx         = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NREQ) w_idx = w_idx - NREQ;
         if (req_valid[w_idx]) begin
            w_grant_found = 1'b1;
            w_grant_id    = IDW'(w_idx);
         end
      end
   end

   assign w_grant_a  = req_a[w_grant_id*W +: W];
   assign w_grant_b  = req_b[w_grant_id*W +: W];
   assign w_take     = (r_state == S_IDLE) && w_grant_found;
   assign w_done     = (r_state == S_RESP) && rsp_ready;
   assign w_ptr_next = (r_id == IDW'(NREQ - 1)) ? '0 : r_id + 1'b1;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
         assign req_ready[gi] = w_take && (w_grant_id == IDW'(gi));
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_take) w_state_next = S_CALC;
         S_CALC:  w_state_next = S_RESP;
         S_RESP:  if (w_done) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_rr_ptr  <= '0;
         r_id      <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_sum     <= '0;
         r_rsp_id  <= '0;
         r_txn_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_take) begin
            r_a  <= w_grant_a;
            r_b  <= w_grant_b;
            r_id <= w_grant_id;
         end
         if (r_state == S_CALC) begin
            r_sum    <= {1'b0, r_a} + {1'b0, r_b};
            r_rsp_id <= r_id;
         end
         // The pointer advances only on completion, so a grant never skips ahead.
         if (w_done) begin
            r_rr_ptr <= w_ptr_next;
            if (r_txn_cnt != 8'hFF) r_txn_cnt <= r_txn_cnt + 8'd1;
         end
      end
   end

   assign rsp_valid = (r_state == S_RESP);
   assign busy      = (r_state != S_IDLE);
   assign rsp_id    = r_rsp_id;
   assign rsp_sum   = r_sum;
   assign txn_cnt   = r_txn_cnt;

endmodule

// File: tb/tb_adder_share_arb.sv
// Bench for adder_share_arb: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_adder_share_arb;
   localparam int NREQ = 4;
   localparam int W    = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [W:0]        rsp_sum;
   logic              rsp_ready = 1'b0;
   logic              busy;
   logic [7:0]        txn_cnt;

   adder_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum),
      .rsp_ready(rsp_ready), .busy(busy), .txn_cnt(txn_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: transaction in flight, cycles since its grant, pointer, counter.
   bit m_busy = 1'b0;
   int m_age = 0, m_id = 0, m_sum = 0, m_ptr = 0, m_cnt = 0;
   int g, exp_ready, cyc = 0, hs_count = 0;
   bit exp_valid;
   int grant_log[$], grant_cyc[$], rsp_id_log[$], rsp_sum_log[$], hs_cyc[$];

   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_busy = 1'b0; m_age = 0; m_ptr = 0; m_cnt = 0;
            chk("rst_req_ready", int'(req_ready), 0);
            chk("rst_rsp_valid", int'(rsp_valid), 0);
            chk("rst_rsp_id", int'(rsp_id), 0);
            chk("rst_rsp_sum", int'(rsp_sum), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_txn_cnt", int'(txn_cnt), 0);
         end else begin
            g = -1;
            if (!m_busy)
               for (int k = 0; k < NREQ; k++)
                  if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
            exp_ready = (g >= 0) ? (1 << g) : 0;
            exp_valid = m_busy && (m_age >= 2);
            chk("req_ready", int'(req_ready), exp_ready);
            chk("rsp_valid", int'(rsp_valid), int'(exp_valid));
            chk("busy", int'(busy), int'(m_busy));
            chk("txn_cnt", int'(txn_cnt), m_cnt);
            if (exp_valid) begin
               chk("rsp_id", int'(rsp_id), m_id);
               chk("rsp_sum", int'(rsp_sum), m_sum);
            end
            for (int i = 0; i < NREQ; i++)
               if (req_ready[i]) begin
                  grant_log.push_back(i);
                  grant_cyc.push_back(cyc);
               end
            if (rsp_valid && rsp_ready) begin
               rsp_id_log.push_back(int'(rsp_id));
               rsp_sum_log.push_back(int'(rsp_sum));
               hs_cyc.push_back(cyc);
               hs_count++;
               $display("txn id=%0d sum=%0d cnt_before=%0d", rsp_id, rsp_sum, txn_cnt);
            end
            if (g >= 0) begin
               m_busy = 1'b1; m_age = 1; m_id = g;
               m_sum = int'(req_a[g*W +: W]) + int'(req_b[g*W +: W]);
            end else if (m_busy) begin
               if (m_age >= 2 && rsp_ready) begin
                  m_busy = 1'b0;
                  m_ptr = (m_id + 1) % NREQ;
                  if (m_cnt < 255) m_cnt++;
               end else begin
                  m_age++;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      grant_log.delete(); grant_cyc.delete();
      rsp_id_log.delete(); rsp_sum_log.delete(); hs_cyc.delete();
   endtask

   task automatic set_req(input int i, input int a, input int b);
      req_a[i*W +: W] = W'(a);
      req_b[i*W +: W] = W'(b);
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_grant(input int i);
      int t = 0;
      @(negedge clk);
      while (!req_ready[i] && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("grant_seen", int'(req_ready[i]), 1);
      tick();
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_hs();
      int t = 0;
      @(negedge clk);
      while (!(rsp_valid && rsp_ready) && t < 40) begin
         @(negedge clk);
         t++;
      end
      chk("hs_seen", int'(rsp_valid && rsp_ready), 1);
      tick();
   endtask

   task automatic do_reset();
      req_valid = '0;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
   endtask

   int rr_exp_id[5]  = '{0, 1, 2, 3, 0};
   int rr_exp_sum[5] = '{3, 7, 11, 15, 3};

   initial begin
      rsp_ready = 1'b1;
      repeat (2) tick();
      chk("lit_reset_busy", int'(busy), 0);
      chk("lit_reset_cnt", int'(txn_cnt), 0);
      rst_n = 1'b1;
      tick();

      // Single request with latency check
      clear_logs();
      set_req(0, 3, 4);
      wait_grant(0);
      wait_hs();
      chk("single_grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
      chk("single_id", rsp_id_log.size() > 0 ? rsp_id_log[0] : -1, 0);
      chk("single_sum", rsp_sum_log.size() > 0 ? rsp_sum_log[0] : -1, 7);
      chk("single_latency", (hs_cyc.size() > 0 && grant_cyc.size() > 0) ? hs_cyc[0] - grant_cyc[0] : -1, 2);
      chk("single_cnt", int'(txn_cnt), 1);

      // Carry into the top sum bit
      clear_logs();
      set_req(2, 15, 15);
      wait_grant(2);
      wait_hs();
      chk("carry_id", rsp_id_log.size() > 0 ? rsp_id_log[0] : -1, 2);
      chk("carry_sum", rsp_sum_log.size() > 0 ? rsp_sum_log[0] : -1, 30);

      // Round robin from a fresh pointer
      do_reset();
      clear_logs();
      for (int i = 0; i < NREQ; i++) set_req(i, i + 2, 3 * i + 1);
      begin
         int t = 0;
         while (grant_log.size() < 5 && t < 100) begin
            tick();
            t++;
         end
      end
      req_valid = '0;
      wait_hs();
      chk("rr_grants", grant_log.size(), 5);
      chk("rr_rsps", rsp_sum_log.size(), 5);
      for (int k = 0; k < 5; k++) begin
         if (k < grant_log.size()) chk("rr_order", grant_log[k], rr_exp_id[k]);
         if (k < rsp_sum_log.size()) chk("rr_sum", rsp_sum_log[k], rr_exp_sum[k]);
         if (k > 0 && k < grant_cyc.size()) chk("rr_period", grant_cyc[k] - grant_cyc[k-1], 3);
      end

      // Backpressure held in RESP with another request pending
      rsp_ready = 1'b0;
      set_req(3, 5, 6);
      wait_grant(3);
      set_req(1, 9, 9);
      begin
         int t = 0;
         while (!rsp_valid && t < 5) begin
            tick();
            t++;
         end
      end
      clear_logs();
      repeat (5) begin
         tick();
         chk("bp_valid", int'(rsp_valid), 1);
         chk("bp_sum", int'(rsp_sum), 11);
         chk("bp_id", int'(rsp_id), 3);
         chk("bp_ready", int'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      wait_hs();
      wait_grant(1);
      wait_hs();
      chk("bp_next_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
      chk("bp_grant_after_hs", (grant_cyc.size() > 0 && hs_cyc.size() > 0) ? grant_cyc[0] - hs_cyc[0] : -1, 1);
      chk("bp_sum2", rsp_sum_log.size() > 1 ? rsp_sum_log[1] : -1, 18);

      // Reset while in CALC; pointer was 2 before reset
      set_req(2, 1, 2);
      wait_grant(2);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_valid", int'(rsp_valid), 0);
      chk("mid_rst_sum", int'(rsp_sum), 0);
      chk("mid_rst_cnt", int'(txn_cnt), 0);
      repeat (2) tick();
      rst_n = 1'b1;
      clear_logs();
      repeat (4) tick();
      chk("no_stale_rsp", rsp_id_log.size(), 0);
      set_req(1, 4, 4);
      set_req(3, 7, 7);
      wait_grant(1);
      req_valid[3] = 1'b0;
      wait_hs();
      chk("post_rst_grant", grant_log.size() > 0 ? grant_log[0] : -1, 1);
      chk("post_rst_sum", rsp_sum_log.size() > 0 ? rsp_sum_log[0] : -1, 8);
      chk("post_rst_cnt", int'(txn_cnt), 1);

      // Saturation of the transaction counter
      hs_count = 0;
      for (int i = 0; i < NREQ; i++) set_req(i, i, 15 - i);
      begin
         int t = 0;
         while (hs_count < 260 && t < 260 * 3 + 100) begin
            tick();
            t++;
         end
      end
      req_valid = '0;
      repeat (4) tick();
      chk("sat_hs_count", hs_count >= 260 ? 1 : 0, 1);
      chk("sat_cnt", int'(txn_cnt), 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
